// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready handshake and a sideband tag.
// Optional macro KS_SUB_EN adds a 'sub' port selecting a - b.
module kogge_stone_pipe #(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [TAG_W-1:0] in_tag,
`ifdef KS_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L = $clog2(WIDTH);
    localparam int S = (L + LVL_PER_STG - 1) / LVL_PER_STG;

    // Applies prefix levels lo..hi-1 and returns the group generate vector.
    // Walking i downwards means g[i-span] still holds the previous level's value.
    function automatic logic [WIDTH-1:0] prefix_g(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] pg_in,
                                                  input int lo, input int hi);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] pg;
        // NOTE: blocking updates are deliberate here; each level builds on the one before.
        g  = g_in;
        pg = pg_in;
        for (int k = lo; k < hi; k++) begin
            for (int i = WIDTH - 1; i >= (1 << k); i--) begin
                g[i]  = g[i] | (pg[i] & g[i - (1 << k)]);
                pg[i] = pg[i] & pg[i - (1 << k)];
            end
        end
        return g;
    endfunction

    function automatic logic [WIDTH-1:0] prefix_pg(input logic [WIDTH-1:0] pg_in,
                                                   input int lo, input int hi);
        logic [WIDTH-1:0] pg;
        pg = pg_in;
        for (int k = lo; k < hi; k++) begin
            for (int i = WIDTH - 1; i >= (1 << k); i--) begin
                pg[i] = pg[i] & pg[i - (1 << k)];
            end
        end
        return pg;
    endfunction

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] carry;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

`ifdef KS_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Carry-in folded into bit 0 so the prefix tree needs no separate carry path.
    assign p0 = a ^ b_eff;
    assign g0 = (a & b_eff) | {{(WIDTH - 1){1'b0}}, p0[0] & cin_eff};

    for (genvar s = 0; s < S; s++) begin : stg
        logic             vld_q, vld_d;
        logic [WIDTH-1:0] g_q, g_d;
        logic [WIDTH-1:0] pg_q, pg_d;
        logic [WIDTH-1:0] p_q, p_d;
        logic             cin_q, cin_d;
        logic [TAG_W-1:0] tag_q, tag_d;

        if (s == 0) begin : head
            assign vld_d = in_valid;
            assign g_d   = g0;
            assign pg_d  = p0;
            assign p_d   = p0;
            assign cin_d = cin_eff;
            assign tag_d = in_tag;
        end else begin : body
            localparam int LO = (s - 1) * LVL_PER_STG;
            localparam int HI = s * LVL_PER_STG;
            assign vld_d = stg[s-1].vld_q;
            assign g_d   = prefix_g(stg[s-1].g_q, stg[s-1].pg_q, LO, HI);
            assign pg_d  = prefix_pg(stg[s-1].pg_q, LO, HI);
            assign p_d   = stg[s-1].p_q;
            assign cin_d = stg[s-1].cin_q;
            assign tag_d = stg[s-1].tag_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else if (!stall) begin
                vld_q <= vld_d;
            end
        end

        // NOTE: payload registers carry no reset; the valid bit alone qualifies them.
        always_ff @(posedge clk) begin
            if (!stall) begin
                g_q   <= g_d;
                pg_q  <= pg_d;
                p_q   <= p_d;
                cin_q <= cin_d;
                tag_q <= tag_d;
            end
        end
    end

    // Remaining levels resolve every carry; the sum is formed and registered here.
    assign carry = prefix_g(stg[S-1].g_q, stg[S-1].pg_q, (S - 1) * LVL_PER_STG, L);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_tag   <= '0;
        end else if (!stall) begin
            out_valid <= stg[S-1].vld_q;
            if (stg[S-1].vld_q) begin
                sum     <= stg[S-1].p_q ^ {carry[WIDTH-2:0], stg[S-1].cin_q};
                cout    <= carry[WIDTH-1];
                ovf     <= carry[WIDTH-1] ^ carry[WIDTH-2];
                out_tag <= stg[S-1].tag_q;
            end
        end
    end

endmodule

// File: tb/tb_kogge_stone_pipe.sv
// Directed self-checking bench: 32-bit/2-levels-per-stage and 16-bit/4-levels-per-stage instances.
// Subtract vectors run only when KS_SUB_EN is defined.
module tb_kogge_stone_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, cout, ovf, sub;
    logic [3:0]  in_tag, out_tag;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, sum16;
    logic        cin16, cout16, ovf16, sub16;
    logic [3:0]  in_tag16, out_tag16;

    int checks = 0;
    int errors = 0;

    kogge_stone_pipe #(.WIDTH(32), .LVL_PER_STG(2), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .in_tag(in_tag),
`ifdef KS_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .out_tag(out_tag)
    );

    kogge_stone_pipe #(.WIDTH(16), .LVL_PER_STG(4), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .in_tag(in_tag16),
`ifdef KS_SUB_EN
        .sub(sub16),
`endif
        .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .out_tag(out_tag16)
    );

    // Stream vectors: a, b, cin, tag and hand-computed sum/cout/ovf.
    logic [31:0] va [8] = '{32'h0000_0001, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF,
                            32'h0000_FFFF, 32'h7FFF_FFFF, 32'hAAAA_AAAA, 32'hDEAD_BEEF};
    logic [31:0] vb [8] = '{32'h0000_0001, 32'h8000_0000, 32'h1111_1111, 32'hFFFF_FFFF,
                            32'h0000_0001, 32'h7FFF_FFFF, 32'h5555_5555, 32'h0000_0000};
    logic        vc [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  vt [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [31:0] es [8] = '{32'h0000_0002, 32'h0000_0000, 32'h2345_678A, 32'hFFFF_FFFF,
                            32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF};
    logic        ec [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        eo [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    logic [15:0] wa [4] = '{16'h00FF, 16'h8000, 16'h1234, 16'hAAAA};
    logic [15:0] wb [4] = '{16'h0001, 16'h8000, 16'h1111, 16'h5555};
    logic        wc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ws [4] = '{16'h0100, 16'h0000, 16'h2346, 16'h0000};
    logic        wco [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        wov [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic [3:0] t);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
        in_tag   = t;
    endtask

    task automatic drive16(input logic v, input logic [15:0] x, input logic [15:0] y,
                           input logic c, input logic [3:0] t);
        in_valid16 = v;
        a16        = x;
        b16        = y;
        cin16      = c;
        in_tag16   = t;
    endtask

    int idx_in, idx_out;

    initial begin
        rst = 1'b1;
        sub = 1'b0;
        sub16 = 1'b0;
        out_ready = 1'b1;
        out_ready16 = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);
        drive16(1'b0, '0, '0, 1'b0, '0);
        step();
        chk("rst_in_ready_during", in_ready, 1'b1);
        step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout_ovf", {cout, ovf}, 2'b00);
        chk("rst_out_tag", out_tag, 4'h0);
        chk("rst_out_valid16", out_valid16, 1'b0);

        // Wrap-around with exact latency of 4 edges.
        drive(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'h3);
        step();
        drive(1'b0, '0, '0, 1'b0, '0);
        chk("lat_edge1", out_valid, 1'b0);
        step();
        step();
        chk("lat_edge3", out_valid, 1'b0);
        step();
        chk("wrap_valid", out_valid, 1'b1);
        chk("wrap_sum", sum, 32'h0);
        chk("wrap_cout_ovf", {cout, ovf}, 2'b10);
        chk("wrap_tag", out_tag, 4'h3);
        step();
        chk("wrap_single", out_valid, 1'b0);

        // Signed overflow and tag return.
        drive(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'hA);
        step();
        drive(1'b0, '0, '0, 1'b0, '0);
        step();
        step();
        step();
        chk("ovf_valid", out_valid, 1'b1);
        chk("ovf_sum", sum, 32'h8000_0000);
        chk("ovf_cout_ovf", {cout, ovf}, 2'b01);
        chk("ovf_tag", out_tag, 4'hA);

        // Eight back-to-back operations, results on consecutive cycles.
        idx_in = 0;
        idx_out = 0;
        for (int cyc = 0; cyc < 20 && idx_out < 8; cyc++) begin
            if (idx_in < 8) begin
                drive(1'b1, va[idx_in], vb[idx_in], vc[idx_in], vt[idx_in]);
                idx_in++;
            end else begin
                drive(1'b0, '0, '0, 1'b0, '0);
            end
            step();
            if (out_valid) begin
                chk("stream_cycle", cyc, idx_out + 3);
                chk("stream_sum", sum, es[idx_out]);
                chk("stream_cout_ovf", {cout, ovf}, {ec[idx_out], eo[idx_out]});
                chk("stream_tag", out_tag, vt[idx_out]);
                idx_out++;
            end
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        chk("stream_count", idx_out, 8);
        step();
        chk("stream_drained", out_valid, 1'b0);

        // Fill the pipe with the consumer stalled, hold 5 cycles, then drain.
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, va[j], vb[j], vc[j], vt[j]);
            step();
        end
        drive(1'b1, va[4], vb[4], vc[4], vt[4]);
        for (int h = 0; h < 5; h++) begin
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_sum", sum, es[0]);
            chk("stall_tag", out_tag, vt[0]);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        out_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            step();
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_sum", sum, es[j]);
            chk("drain_tag", out_tag, vt[j]);
        end
        step();
        chk("drain_no_dup", out_valid, 1'b0);
        step();
        chk("drain_no_extra", out_valid, 1'b0);

        // Reset with three operations in flight.
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, va[j], vb[j], vc[j], vt[j]);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        for (int h = 0; h < 6; h++) begin
            step();
            chk("flush_no_stale", out_valid, 1'b0);
        end

`ifdef KS_SUB_EN
        sub = 1'b1;
        drive(1'b1, 32'd5, 32'd7, 1'b0, 4'h5);
        step();
        drive(1'b1, 32'h8000_0000, 32'h1, 1'b0, 4'h6);
        step();
        drive(1'b0, '0, '0, 1'b0, '0);
        sub = 1'b0;
        step();
        step();
        chk("sub_sum", sum, 32'hFFFF_FFFE);
        chk("sub_cout_ovf", {cout, ovf}, 2'b00);
        step();
        chk("sub_ovf_sum", sum, 32'h7FFF_FFFF);
        chk("sub_ovf_cout_ovf", {cout, ovf}, 2'b11);
`endif

        // 16-bit instance, single stage: latency 2.
        drive16(1'b1, 16'hFFFF, 16'h0, 1'b1, 4'h2);
        step();
        drive16(1'b0, '0, '0, 1'b0, '0);
        chk("w16_lat_edge1", out_valid16, 1'b0);
        step();
        chk("w16_wrap_valid", out_valid16, 1'b1);
        chk("w16_wrap_sum", sum16, 16'h0);
        chk("w16_wrap_cout_ovf", {cout16, ovf16}, 2'b10);
        drive16(1'b1, 16'h7FFF, 16'h1, 1'b0, 4'hA);
        step();
        drive16(1'b0, '0, '0, 1'b0, '0);
        step();
        chk("w16_ovf_sum", sum16, 16'h8000);
        chk("w16_ovf_cout_ovf", {cout16, ovf16}, 2'b01);
        chk("w16_ovf_tag", out_tag16, 4'hA);

        idx_in = 0;
        idx_out = 0;
        for (int cyc = 0; cyc < 12 && idx_out < 4; cyc++) begin
            if (idx_in < 4) begin
                drive16(1'b1, wa[idx_in], wb[idx_in], wc[idx_in], vt[idx_in]);
                idx_in++;
            end else begin
                drive16(1'b0, '0, '0, 1'b0, '0);
            end
            step();
            if (out_valid16) begin
                chk("w16_stream_cycle", cyc, idx_out + 1);
                chk("w16_stream_sum", sum16, ws[idx_out]);
                chk("w16_stream_cout_ovf", {cout16, ovf16}, {wco[idx_out], wov[idx_out]});
                chk("w16_stream_tag", out_tag16, vt[idx_out]);
                idx_out++;
            end
        end
        drive16(1'b0, '0, '0, 1'b0, '0);
        chk("w16_stream_count", idx_out, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
